// File: rtl/traffic_light_timer.sv
`default_nettype none
// ============================================================================
// Module   : traffic_light_timer
// Purpose  : Per-phase countdown timer with 1 s prescaler, expiry pulses and
//            BCD display digits for the traffic-light phase FSM.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_light_timer #(
    parameter int TICK_DIV    = 50_000_000,
    parameter int GREEN_TIME  = 30,
    parameter int YELLOW_TIME = 3,
    parameter int RED_TIME    = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       state_green,
    input  logic       state_yellow,
    input  logic       state_red,
    output logic       green_end,
    output logic       yellow_end,
    output logic       red_end,
    output logic [6:0] remaining,
    output logic [3:0] remaining_tens,
    output logic [3:0] remaining_units,
    output logic       phase_fault
);

    localparam int PW = $clog2(TICK_DIV);

    localparam logic [PW-1:0] c_presc_max = PW'(TICK_DIV - 1);
    localparam logic [2:0]    c_ph_green  = 3'b100;
    localparam logic [2:0]    c_ph_yellow = 3'b010;
    localparam logic [2:0]    c_ph_red    = 3'b001;

    logic [PW-1:0] r_presc;
    logic [6:0]    r_cnt;
    logic [2:0]    r_phase_q;
    logic          r_green_end;
    logic          r_yellow_end;
    logic          r_red_end;
    logic          r_fault;

    logic [2:0]    w_phase;
    logic          w_valid;
    logic          w_load;
    logic [6:0]    w_duration;
    logic [3:0]    w_tens;
    logic [3:0]    w_units;

    assign w_phase = {state_green, state_yellow, state_red};
    assign w_valid = (w_phase == c_ph_green) || (w_phase == c_ph_yellow) ||
                     (w_phase == c_ph_red);
    assign w_load  = w_valid && (w_phase != r_phase_q);

    always_comb begin
        w_duration = 7'd0;
        case (w_phase)
            c_ph_green:  w_duration = 7'(GREEN_TIME);
            c_ph_yellow: w_duration = 7'(YELLOW_TIME);
            c_ph_red:    w_duration = 7'(RED_TIME);
            default:     w_duration = 7'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc      <= '0;
            r_cnt        <= 7'd0;
            r_phase_q    <= 3'b000;
            r_green_end  <= 1'b0;
            r_yellow_end <= 1'b0;
            r_red_end    <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_green_end  <= 1'b0;
            r_yellow_end <= 1'b0;
            r_red_end    <= 1'b0;
            if (!w_valid) begin
                // Clearing phase_q makes the next valid phase reload from scratch.
                r_presc   <= '0;
                r_cnt     <= 7'd0;
                r_phase_q <= 3'b000;
                r_fault   <= 1'b1;
            end else begin
                r_fault <= 1'b0;
                if (w_load) begin
                    r_presc   <= '0;
                    r_cnt     <= w_duration;
                    r_phase_q <= w_phase;
                end else if (r_cnt != 7'd0) begin
                    if (r_presc == c_presc_max) begin
                        r_presc <= '0;
                        r_cnt   <= r_cnt - 7'd1;
                        if (r_cnt == 7'd1) begin
                            r_green_end  <= r_phase_q[2];
                            r_yellow_end <= r_phase_q[1];
                            r_red_end    <= r_phase_q[0];
                        end
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                end
            end
        end
    end

    // Divide-by-10 via a comparator ladder; units use mod-16 arithmetic since
    // the true remainder always fits in four bits.
    always_comb begin
        w_tens = 4'd0;
        for (int k = 1; k <= 9; k++) begin
            if (r_cnt >= 7'(k * 10)) begin
                w_tens = 4'(k);
            end
        end
        w_units = r_cnt[3:0] - (w_tens * 4'd10);
    end

    assign green_end       = r_green_end;
    assign yellow_end      = r_yellow_end;
    assign red_end         = r_red_end;
    assign remaining       = r_cnt;
    assign remaining_tens  = w_tens;
    assign remaining_units = w_units;
    assign phase_fault     = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_light_timer
// Purpose  : Directed self-checking bench for traffic_light_timer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_light_timer;

    logic       clk;
    logic       rst_n;
    logic       state_green;
    logic       state_yellow;
    logic       state_red;
    logic       green_end;
    logic       yellow_end;
    logic       red_end;
    logic [6:0] remaining;
    logic [3:0] remaining_tens;
    logic [3:0] remaining_units;
    logic       phase_fault;

    int n_vec = 0;
    int n_err = 0;

    traffic_light_timer #(
        .TICK_DIV    (4),
        .GREEN_TIME  (5),
        .YELLOW_TIME (2),
        .RED_TIME    (3)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .state_green     (state_green),
        .state_yellow    (state_yellow),
        .state_red       (state_red),
        .green_end       (green_end),
        .yellow_end      (yellow_end),
        .red_end         (red_end),
        .remaining       (remaining),
        .remaining_tens  (remaining_tens),
        .remaining_units (remaining_units),
        .phase_fault     (phase_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_ends(input string tag, input logic g, input logic y, input logic r);
        check(tag, {29'd0, green_end, yellow_end, red_end}, {29'd0, g, y, r});
    endtask

    // Advance one rising edge and come back to the falling edge for sampling.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_phase(input logic g, input logic y, input logic r);
        state_green  = g;
        state_yellow = y;
        state_red    = r;
    endtask

    initial begin
        rst_n = 1'b0;
        set_phase(1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);

        check("rst_remaining", 32'(remaining), 32'd0);
        check("rst_fault", 32'(phase_fault), 32'd0);
        check_ends("rst_ends", 1'b0, 1'b0, 1'b0);

        rst_n = 1'b1;
        step();
        check("zero_hot_fault", 32'(phase_fault), 32'd1);
        check("zero_hot_remaining", 32'(remaining), 32'd0);
        check_ends("zero_hot_ends", 1'b0, 1'b0, 1'b0);

        // Green load and full countdown
        set_phase(1'b1, 1'b0, 1'b0);
        step();
        check("green_load_cnt", 32'(remaining), 32'd5);
        check("green_load_fault", 32'(phase_fault), 32'd0);
        check("green_load_tens", 32'(remaining_tens), 32'd0);
        check("green_load_units", 32'(remaining_units), 32'd5);
        for (int i = 1; i <= 21; i++) begin
            step();
            check("green_cnt", 32'(remaining), 32'(5 - ((i > 20 ? 20 : i) / 4)));
            check("green_units", 32'(remaining_units), 32'(5 - ((i > 20 ? 20 : i) / 4)));
            check_ends("green_pulse", (i == 20), 1'b0, 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            check("green_idle_cnt", 32'(remaining), 32'd0);
            check_ends("green_idle_ends", 1'b0, 1'b0, 1'b0);
        end

        // Yellow
        set_phase(1'b0, 1'b1, 1'b0);
        step();
        check("yellow_load_cnt", 32'(remaining), 32'd2);
        for (int i = 1; i <= 9; i++) begin
            step();
            check("yellow_cnt", 32'(remaining), 32'(2 - ((i > 8 ? 8 : i) / 4)));
            check_ends("yellow_pulse", 1'b0, (i == 8), 1'b0);
        end

        // Red
        set_phase(1'b0, 1'b0, 1'b1);
        step();
        check("red_load_cnt", 32'(remaining), 32'd3);
        for (int i = 1; i <= 13; i++) begin
            step();
            check("red_cnt", 32'(remaining), 32'(3 - ((i > 12 ? 12 : i) / 4)));
            check_ends("red_pulse", 1'b0, 1'b0, (i == 12));
        end

        // Green interrupted by red on the very cycle it would expire
        set_phase(1'b1, 1'b0, 1'b0);
        step();
        check("green2_load_cnt", 32'(remaining), 32'd5);
        repeat (19) step();
        check("green2_last_sec", 32'(remaining), 32'd1);
        set_phase(1'b0, 1'b0, 1'b1);
        step();
        check("preempt_cnt", 32'(remaining), 32'd3);
        check_ends("preempt_ends", 1'b0, 1'b0, 1'b0);
        step();
        check_ends("preempt_ends_next", 1'b0, 1'b0, 1'b0);
        check("preempt_cnt_next", 32'(remaining), 32'd3);

        // Multi-hot fault mid-count
        set_phase(1'b1, 1'b0, 1'b1);
        step();
        check("multi_hot_fault", 32'(phase_fault), 32'd1);
        check("multi_hot_cnt", 32'(remaining), 32'd0);
        check_ends("multi_hot_ends", 1'b0, 1'b0, 1'b0);
        repeat (5) begin
            step();
            check_ends("multi_hot_hold_ends", 1'b0, 1'b0, 1'b0);
            check("multi_hot_hold_fault", 32'(phase_fault), 32'd1);
        end
        set_phase(1'b0, 1'b0, 1'b1);
        step();
        check("recover_fault", 32'(phase_fault), 32'd0);
        check("recover_cnt", 32'(remaining), 32'd3);

        // Asynchronous reset mid-yellow, then reload on release
        set_phase(1'b0, 1'b1, 1'b0);
        step();
        check("yellow2_load_cnt", 32'(remaining), 32'd2);
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_cnt", 32'(remaining), 32'd0);
        check("async_rst_fault", 32'(phase_fault), 32'd0);
        check_ends("async_rst_ends", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("rst_hold_cnt", 32'(remaining), 32'd0);
        rst_n = 1'b1;
        step();
        check("yellow_reload_cnt", 32'(remaining), 32'd2);
        check("yellow_reload_tens", 32'(remaining_tens), 32'd0);
        for (int i = 1; i <= 9; i++) begin
            step();
            check("yellow_reload_run", 32'(remaining), 32'(2 - ((i > 8 ? 8 : i) / 4)));
            check_ends("yellow_reload_pulse", 1'b0, (i == 8), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
